dac_stream_out: RTL
===================

Name: dac_stream_out

Overview:
- Output stage between the processor system's sample-write path and the 8-bit parallel DAC pins (`dac_data`, `dac_clk`).
- Buffers CPU-written samples in a synchronous FIFO.
- Pops one sample per programmable sample period derived from `hclk`, and generates the DAC latch clock with data stable around its rising edge.
- Reports buffer level, underflow and overflow to software.

Parameters:
- DATA_W, 8, sample/DAC width
- DEPTH_LOG2, 8, FIFO depth = 2^DEPTH_LOG2 entries
- DIV_W, 16, width of sample-period divider
- IDLE_CODE, 8'h80, value driven on `dac_data` while disabled/reset (DAC midscale)

Ports:
- `hclk` input 1 system clock (50 MHz)
- `rst` input 1 synchronous active-high reset
- `wr_en` input 1 sample write strobe
- `wr_data` input DATA_W sample to enqueue
- `wr_ready` output 1 FIFO not full
- `enable` input 1 playback enable
- `flush` input 1 one-cycle pulse: empty FIFO
- `div` input DIV_W sample period = max(div,1)+1 `hclk` cycles
- `clr_flags` input 1 clear sticky flags
- `level` output DEPTH_LOG2+1 FIFO occupancy
- `underflow` output 1 sticky: sample tick with FIFO empty
- `overflow` output 1 sticky: write while full
- `dac_data` output DATA_W DAC data bus, registered
- `dac_clk` output 1 DAC latch clock, registered

Behaviour:
- Reset (`rst`=1 at `hclk` rising edge) values:
  - FIFO pointers cleared; `level`=0; `wr_ready`=1
  - `underflow`=0, `overflow`=0
  - `dac_data`=IDLE_CODE; `dac_clk`=0
  - phase counter=0
  - Reset mid-playback discards FIFO contents immediately.
- FIFO:
  - Write accepted when `wr_en` && !full; `level` increments the cycle after.
  - Write while full: data dropped, `overflow` set.
  - `wr_ready` = !full (registered level based, no combinational path from `wr_en`).
  - Simultaneous accepted write and pop: `level` unchanged.
  - Write into an empty FIFO is not visible to a pop in the same cycle.
  - `flush` empties the FIFO; a write in the same cycle as `flush` is discarded.
- Effective period: P = max(`div`,1)+1, so `div`=0 behaves as `div`=1 (minimum period 2 cycles, 25 MS/s).
- Phase counter `cnt` in 0..P-1, running while `enable`=1:
  - tick when `cnt`==P-1, then `cnt` wraps to 0.
  - `div` is sampled only at the wrap, so a mid-period change takes effect on the next period.
- On tick:
  - FIFO non-empty: pop; `dac_data` <= head sample, updated on the edge where `cnt` becomes 0.
  - FIFO empty: `dac_data` holds its previous value and `underflow` is set.
- `dac_clk` <= (`cnt_next` >= P>>1):
  - low for the first P>>1 cycles of each period, high for the rest.
  - rising edge lies mid-period, so data has ≥1 `hclk` of setup and hold.
  - Example P=2: `dac_clk` toggles every cycle, data changes on the falling transition.
- `enable` falling:
  - next cycle `cnt`=0, `dac_clk`=0, `dac_data`=IDLE_CODE.
  - FIFO contents retained.
- `enable` rising: first tick occurs P cycles later; the first sample appears then.
- Sticky flags:
  - cleared by `clr_flags`.
  - A set event in the same cycle as `clr_flags` wins (flag stays 1).
- `level` = write pointer − read pointer, with an extra pointer MSB, so full gives `level`=2^DEPTH_LOG2.

Optional Feature:
- Macro: DAC_SIGNED_IN_EN.
- Defined: `wr_data` is two's complement; the MSB is inverted when loaded into `dac_data` (offset binary for the DAC). IDLE_CODE is output unmodified.
- Undefined: samples pass to `dac_data` unmodified (offset binary input).

Test Plan:
- Reset, then write 4 samples 0x10,0x20,0x30,0x40 with `enable`=0 -> `level`=4, `dac_data`=0x80, `dac_clk`=0 throughout.
- `div`=3 (P=4), set `enable` -> `dac_data` shows 0x10,0x20,0x30,0x40 at 4-cycle spacing; `dac_clk` is 0,0,1,1 per period; `level` decrements to 0; on the 5th tick `underflow`=1 and `dac_data` stays 0x40.
- Write 257 samples with DEPTH_LOG2=8 and `enable`=0 -> `wr_ready`=0 after the 256th, `level`=256, `overflow`=1, 257th sample never output; `clr_flags` -> `overflow`=0.
- `div`=0 with 3 samples queued -> period 2, `dac_clk` toggles each cycle, one sample per 2 cycles.
- Playback with 10 samples queued, assert `rst` after the 2nd output -> next cycle `level`=0, `dac_data`=0x80, `dac_clk`=0; after release with `enable`=1, a tick gives `underflow`=1.
- DAC_SIGNED_IN_EN defined: write 0x00, 0x7F, 0x80 -> `dac_data` 0x80, 0xFF, 0x00.

Source files
------------

// File: rtl/dac_stream_out.sv
// dac_stream_out: CPU sample FIFO feeding an 8-bit parallel DAC.
// Samples are popped once per programmable period and presented on dac_data,
// with dac_clk rising mid-period so the data is stable around the latch edge.
// Optional build macro DAC_SIGNED_IN_EN: treat wr_data as two's complement and
// convert to offset binary (MSB inverted) on the way to the DAC.
module dac_stream_out #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       DEPTH_LOG2 = 8,
    parameter int unsigned       DIV_W      = 16,
    parameter logic [DATA_W-1:0] IDLE_CODE  = 'h80
) (
    input  logic                  hclk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  wr_ready,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [DIV_W-1:0]      div,
    input  logic                  clr_flags,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underflow,
    output logic                  overflow,
    output logic [DATA_W-1:0]     dac_data,
    output logic                  dac_clk
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DIV_W + 1;

    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;

    // Phase counter and the period latched at the last wrap.
    logic [PW-1:0] cnt;
    logic [PW-1:0] per_q;

    logic          full;
    logic          empty;
    logic          push;
    logic          tick;
    logic          pop;
    logic [PW-1:0] div_eff;
    logic [PW-1:0] cnt_next;
    logic [PW-1:0] per_next;
    logic          clk_next;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] out_sample;

    // Extra pointer MSB distinguishes full from empty.
    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    assign wr_ready = !full;

    // A write coinciding with flush is dropped along with the queue.
    assign push = wr_en && !full && !flush;
    assign tick = enable && (cnt == per_q - PW'(1));
    assign pop  = tick && !empty;

    assign head = mem[rd_ptr[DEPTH_LOG2-1:0]];

`ifdef DAC_SIGNED_IN_EN
    assign out_sample = head ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
    assign out_sample = head;
`endif

    // Effective period and next phase; div only matters at a wrap or while idle.
    always_comb begin
        div_eff  = (div == '0) ? PW'(2) : ({1'b0, div} + PW'(1));
        cnt_next = '0;
        per_next = per_q;
        if (!enable || tick) begin
            per_next = div_eff;
        end
        if (enable && !tick) begin
            cnt_next = cnt + PW'(1);
        end
        // Low for the first half of the period; after a wrap cnt_next is 0 so
        // the clock always starts low.
        clk_next = (cnt_next >= (per_next >> 1));
    end

    // Sample storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge hclk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Pointers, sticky flags, phase counter and registered DAC outputs.
    always_ff @(posedge hclk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            cnt       <= '0;
            per_q     <= div_eff;
            dac_clk   <= 1'b0;
            dac_data  <= IDLE_CODE;
        end else begin
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            // A set event in the same cycle as clr_flags keeps the flag set.
            underflow <= (underflow && !clr_flags) || (tick && empty);
            overflow  <= (overflow && !clr_flags) || (wr_en && full);
            cnt       <= cnt_next;
            per_q     <= per_next;
            dac_clk   <= clk_next;
            if (!enable) begin
                dac_data <= IDLE_CODE;
            end else if (pop) begin
                dac_data <= out_sample;
            end
        end
    end

endmodule
